axil_cfg_sequencer: RTL

// - AXI4-Lite master that sequences single register writes/reads into the AXI4_read_ram PWM/register slave.
// - Accepts one command at a time on a valid/ready command port, runs the matching AXI4-Lite transaction, and returns status/read data on a response port.
// - Replaces bench-style axi_write/axi_read tasks with synthesizable logic so firmware or other on-chip logic can drive slave registers.
//

---
 rtl/axil_cfg_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_cfg_sequencer.sv
// axil_cfg_sequencer: AXI4-Lite master that runs one register write or read
// per command and returns the slave's status and read data on a response port.
// Optional build macro: SEQ_TIMEOUT_EN enables the per-phase handshake timeout.
module axil_cfg_sequencer #(
  parameter int C_M00_AXI_ADDR_WIDTH = 14,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 256
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_areset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic [15:0]                       txn_count,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam int SW = C_M00_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  state_t          state_r, state_s;
  logic            cmd_ready_r, cmd_ready_s;
  logic            awvalid_r, awvalid_s;
  logic            wvalid_r, wvalid_s;
  logic            bready_r, bready_s;
  logic            arvalid_r, arvalid_s;
  logic            rready_r, rready_s;
  logic            aw_done_r, aw_done_s;
  logic            w_done_r, w_done_s;
  logic            rsp_valid_r, rsp_valid_s;
  logic [DW-1:0]   rsp_rdata_r, rsp_rdata_s;
  logic [1:0]      rsp_resp_r, rsp_resp_s;
  logic            rsp_timeout_r, rsp_timeout_s;
  logic [15:0]     txn_count_r, txn_count_s;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   wdata_r;
  logic [SW-1:0]   wstrb_r;
  logic            cmd_hs_s;
  logic            aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic            tmo_hit_s;

  assign aw_hs_s = awvalid_r & m00_axi_awready;
  assign w_hs_s  = wvalid_r  & m00_axi_wready;
  assign b_hs_s  = bready_r  & m00_axi_bvalid;
  assign ar_hs_s = arvalid_r & m00_axi_arready;
  assign r_hs_s  = rready_r  & m00_axi_rvalid;

`ifdef SEQ_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  logic [TCW-1:0] tmo_cnt_r;
  logic           tmo_count_en_s;

  assign tmo_count_en_s = (state_r == ST_WR_AW_W) || (state_r == ST_WR_B) ||
                          (state_r == ST_RD_AR)   || (state_r == ST_RD_R);
  assign tmo_hit_s      = tmo_count_en_s && (tmo_cnt_r == TMO_LAST);

  // Per-phase wait counter: restarts on every state change, runs only while waiting on the slave.
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      tmo_cnt_r <= {TCW{1'b0}};
    end else if (state_s != state_r) begin
      tmo_cnt_r <= {TCW{1'b0}};
    end else if (tmo_count_en_s) begin
      tmo_cnt_r <= tmo_cnt_r + TCW'(1);
    end else begin
      tmo_cnt_r <= {TCW{1'b0}};
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s       = state_r;
    cmd_ready_s   = cmd_ready_r;
    awvalid_s     = awvalid_r;
    wvalid_s      = wvalid_r;
    bready_s      = bready_r;
    arvalid_s     = arvalid_r;
    rready_s      = rready_r;
    aw_done_s     = aw_done_r;
    w_done_s      = w_done_r;
    rsp_valid_s   = rsp_valid_r;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_resp_s    = rsp_resp_r;
    rsp_timeout_s = rsp_timeout_r;
    txn_count_s   = txn_count_r;
    cmd_hs_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (cmd_valid && cmd_ready_r) begin
          cmd_hs_s    = 1'b1;
          cmd_ready_s = 1'b0;
          if (cmd_write) begin
            state_s   = ST_WR_AW_W;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
            aw_done_s = 1'b0;
            w_done_s  = 1'b0;
          end else begin
            state_s   = ST_RD_AR;
            arvalid_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_AW_W: begin
        // Address and data channels complete independently, in any order.
        if (aw_hs_s) begin
          awvalid_s = 1'b0;
          aw_done_s = 1'b1;
        end else begin
          awvalid_s = awvalid_r;
        end
        if (w_hs_s) begin
          wvalid_s = 1'b0;
          w_done_s = 1'b1;
        end else begin
          wvalid_s = wvalid_r;
        end
        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
          state_s   = ST_WR_B;
          bready_s  = 1'b1;
          aw_done_s = 1'b0;
          w_done_s  = 1'b0;
        end else begin
          state_s = ST_WR_AW_W;
        end
      end
      ST_WR_B: begin
        if (b_hs_s) begin
          state_s       = ST_RSP;
          bready_s      = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_resp_s    = m00_axi_bresp;
          rsp_rdata_s   = {DW{1'b0}};
          rsp_timeout_s = 1'b0;
        end else begin
          state_s = ST_WR_B;
        end
      end
      ST_RD_AR: begin
        if (ar_hs_s) begin
          state_s   = ST_RD_R;
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
        end else begin
          state_s = ST_RD_AR;
        end
      end
      ST_RD_R: begin
        if (r_hs_s) begin
          state_s       = ST_RSP;
          rready_s      = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_resp_s    = m00_axi_rresp;
          rsp_rdata_s   = m00_axi_rdata;
          rsp_timeout_s = 1'b0;
        end else begin
          state_s = ST_RD_R;
        end
      end
      ST_RSP: begin
        // Response is held until consumed; cmd_ready comes back with IDLE.
        if (rsp_valid_r && rsp_ready) begin
          state_s     = ST_IDLE;
          rsp_valid_s = 1'b0;
          cmd_ready_s = 1'b1;
          txn_count_s = txn_count_r + 16'd1;
        end else begin
          state_s = ST_RSP;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cmd_ready_s = 1'b0;
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        bready_s    = 1'b0;
        arvalid_s   = 1'b0;
        rready_s    = 1'b0;
        aw_done_s   = 1'b0;
        w_done_s    = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
    // A phase that is still waiting when its budget runs out is abandoned.
    if (tmo_hit_s && (state_s == state_r)) begin
      state_s       = ST_RSP;
      awvalid_s     = 1'b0;
      wvalid_s      = 1'b0;
      bready_s      = 1'b0;
      arvalid_s     = 1'b0;
      rready_s      = 1'b0;
      aw_done_s     = 1'b0;
      w_done_s      = 1'b0;
      rsp_valid_s   = 1'b1;
      rsp_resp_s    = 2'b10;
      rsp_rdata_s   = {DW{1'b0}};
      rsp_timeout_s = 1'b1;
    end else begin
      state_s = state_s;
    end
  end

  // State and output registers, all cleared by reset.
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state_r       <= ST_IDLE;
      cmd_ready_r   <= 1'b0;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      arvalid_r     <= 1'b0;
      rready_r      <= 1'b0;
      aw_done_r     <= 1'b0;
      w_done_r      <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DW{1'b0}};
      rsp_resp_r    <= 2'b00;
      rsp_timeout_r <= 1'b0;
      txn_count_r   <= 16'd0;
    end else begin
      state_r       <= state_s;
      cmd_ready_r   <= cmd_ready_s;
      awvalid_r     <= awvalid_s;
      wvalid_r      <= wvalid_s;
      bready_r      <= bready_s;
      arvalid_r     <= arvalid_s;
      rready_r      <= rready_s;
      aw_done_r     <= aw_done_s;
      w_done_r      <= w_done_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_resp_r    <= rsp_resp_s;
      rsp_timeout_r <= rsp_timeout_s;
      txn_count_r   <= txn_count_s;
    end
  end

  // Command latch: address/data/strobes stay stable for the whole transaction.
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
      wstrb_r <= {SW{1'b0}};
    end else if (cmd_hs_s) begin
      addr_r  <= cmd_addr;
      wdata_r <= cmd_wdata;
      wstrb_r <= cmd_wstrb;
    end else begin
      addr_r  <= addr_r;
    end
  end

  assign cmd_ready       = cmd_ready_r;
  assign rsp_valid       = rsp_valid_r;
  assign rsp_rdata       = rsp_rdata_r;
  assign rsp_resp        = rsp_resp_r;
  assign rsp_timeout     = rsp_timeout_r;
  assign txn_count       = txn_count_r;
  assign m00_axi_awaddr  = addr_r;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = awvalid_r;
  assign m00_axi_wdata   = wdata_r;
  assign m00_axi_wstrb   = wstrb_r;
  assign m00_axi_wvalid  = wvalid_r;
  assign m00_axi_bready  = bready_r;
  assign m00_axi_araddr  = addr_r;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arvalid = arvalid_r;
  assign m00_axi_rready  = rready_r;

endmodule
